// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3/FSM enums, widths and request-legality helper
//   for the data-memory responder and its byte-lane aligner.
package mem_pkg;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Encodings with no access size, and unsigned variants used as stores.
    function automatic logic type_illegal(input logic [2:0] t, input logic wr);
        return (t == 3'b011) || (t[2:1] == 2'b11) || (wr && t[2]);
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane alignment for loads and stores.
//   i_off       byte offset within the word (addr[1:0])
//   i_type      funct3 access type
//   i_word      current contents of the addressed word
//   i_wdata     unaligned store data (rs2)
//   o_store     word with the store lanes merged in
//   o_load      selected and sign/zero-extended load value
//   o_misalign  halfword on odd address or word on non-zero offset
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_type,
    input  logic [XLEN-1:0] i_word,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_store,
    output logic [XLEN-1:0] o_load,
    output logic            o_misalign
);
    logic [4:0]      w_bsh;
    logic [4:0]      w_hsh;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_bmask;
    logic [XLEN-1:0] w_hmask;

    assign w_bsh   = {i_off, 3'b000};
    assign w_hsh   = {i_off[1], 4'b0000};
    assign w_byte  = i_word[w_bsh +: 8];
    assign w_half  = i_off[1] ? i_word[31:16] : i_word[15:0];
    assign w_bmask = 32'h0000_00FF << w_bsh;
    assign w_hmask = 32'h0000_FFFF << w_hsh;

    assign o_misalign = (i_type[1:0] == 2'b01 && i_off[0]) ||
                        (i_type[1:0] == 2'b10 && i_off != 2'b00);

    assign o_load = (i_type == MEM_B)  ? {{24{w_byte[7]}}, w_byte} :
                    (i_type == MEM_BU) ? {24'b0, w_byte} :
                    (i_type == MEM_H)  ? {{16{w_half[15]}}, w_half} :
                    (i_type == MEM_HU) ? {16'b0, w_half} :
                    (i_type == MEM_W)  ? i_word : '0;

    assign o_store = (i_type == MEM_B) ? (i_word & ~w_bmask) | ({24'b0, i_wdata[7:0]} << w_bsh) :
                     (i_type == MEM_H) ? (i_word & ~w_hmask) | ({16'b0, i_wdata[15:0]} << w_hsh) :
                     (i_type == MEM_W) ? i_wdata : i_word;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data memory with fixed access latency.
//   CLK/RSTn                 clock, asynchronous active-low reset
//   ReqValid/ReqReady        request handshake
//   ReqAddr/ReqWrite/ReqType/ReqWData  byte address, store flag, funct3, rs2 data
//   RspValid/RspReady        response handshake
//   RspRData/RspErr          extended load data (0 for stores/errors), error flag
module dmem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
)(
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            ReqValid,
    output logic            ReqReady,
    input  logic [XLEN-1:0] ReqAddr,
    input  logic            ReqWrite,
    input  logic [2:0]      ReqType,
    input  logic [XLEN-1:0] ReqWData,
    output logic            RspValid,
    input  logic            RspReady,
    output logic [XLEN-1:0] RspRData,
    output logic            RspErr
);
    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    state_e                r_state;
    state_e                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [XLEN-1:0]       r_addr;
    logic [XLEN-1:0]       r_wdata;
    logic [XLEN-1:0]       r_rdata;
    logic [2:0]            r_type;
    logic                  r_write;
    logic                  r_err;
    logic [XLEN-1:0]       r_mem [DEPTH];

    logic                  w_idle;
    logic                  w_accept;
    logic                  w_access;
    logic [XLEN-1:0]       w_addr;
    logic [XLEN-1:0]       w_wdata;
    logic [2:0]            w_type;
    logic                  w_write;
    logic [ADDR_WIDTH-3:0] w_idx;
    logic [XLEN-1:0]       w_word;
    logic [XLEN-1:0]       w_store;
    logic [XLEN-1:0]       w_load;
    logic                  w_misalign;
    logic                  w_oor;
    logic                  w_err;

    assign w_idle   = r_state == IDLE;
    assign w_accept = w_idle && ReqValid;

    // With LATENCY=1 the access happens on the accept edge, so it must use
    // the live request; otherwise it uses the latched copy.
    assign w_addr  = w_idle ? ReqAddr  : r_addr;
    assign w_wdata = w_idle ? ReqWData : r_wdata;
    assign w_type  = w_idle ? ReqType  : r_type;
    assign w_write = w_idle ? ReqWrite : r_write;

    assign w_access = RSTn && ((r_state == WAIT && r_cnt == '0) || (w_accept && LATENCY == 1));

    assign w_idx  = w_addr[ADDR_WIDTH-1:2];
    assign w_word = r_mem[w_idx];
    assign w_oor  = (w_addr >> ADDR_WIDTH) != '0;
    assign w_err  = w_misalign || w_oor || type_illegal(w_type, w_write);

    mem_lane_align u_align (
        .i_off      (w_addr[1:0]),
        .i_type     (w_type),
        .i_word     (w_word),
        .i_wdata    (w_wdata),
        .o_store    (w_store),
        .o_load     (w_load),
        .o_misalign (w_misalign)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (ReqValid) w_next = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (r_cnt == '0) w_next = RESP;
            RESP:    if (RspReady) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_type  <= '0;
            r_write <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= ReqAddr;
                r_wdata <= ReqWData;
                r_type  <= ReqType;
                r_write <= ReqWrite;
                r_cnt   <= CNT_W'(LATENCY - 1);
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_access) begin
                r_rdata <= (w_err || w_write) ? '0 : w_load;
                r_err   <= w_err;
            end
        end
    end

    // Backing store: not reset; the write fires only on the edge entering RESP.
    always_ff @(posedge CLK) begin
        if (w_access && w_write && !w_err) r_mem[w_idx] <= w_store;
    end

    assign ReqReady = w_idle;
    assign RspValid = r_state == RESP;
    assign RspRData = r_rdata;
    assign RspErr   = r_err;
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Handshaked data-memory responder for the multi-cycle and pipelined cores. It receives load/store requests from the CPU memory stage over a valid/ready request channel and performs byte-lane alignment, store merging and load sign/zero extension internally. After a fixed access latency it returns data, or an error flag, over a valid/ready response channel. It replaces the single-cycle data memory wherever the core must tolerate wait states.

## Interface
Parameters:
- ADDR_WIDTH, 17: byte-address width of the backing store; depth is 2**(ADDR_WIDTH-2) 32-bit words.
- LATENCY, 2: cycles from request acceptance to RspValid; legal range 1..15.

Ports (clock is CLK; reset is RSTn, asynchronous, active-low):
- CLK  in  1  clock, all state updates on rising edge
- RSTn  in  1  asynchronous active-low reset
- ReqValid  in  1  request present
- ReqReady  out  1  responder can accept a request
- ReqAddr  in  32  byte address
- ReqWrite  in  1  1 = store, 0 = load
- ReqType  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only
- ReqWData  in  32  unaligned store data (rs2 value)
- RspValid  out  1  response present
- RspReady  in  1  consumer takes response
- RspRData  out  32  extended load data; 0 for stores and errors
- RspErr  out  1  misaligned, out-of-range or illegal-type request

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - ReqReady=1.
  - On ReqValid: latch addr, write, type and wdata.
  - Load the wait counter with LATENCY-1.
  - Go to WAIT, or go directly to RESP when LATENCY=1.
- WAIT:
  - ReqReady=0.
  - The counter decrements each cycle.
  - At 0, perform the access and go to RESP.
- RESP:
  - RspValid=1.
  - RspRData and RspErr are held stable until RspValid&&RspReady, then return to IDLE.
- Error conditions:
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - addr ≥ 2**ADDR_WIDTH.
  - ReqType in {011,110,111}, or a store with type[2]=1.
- An errored request writes nothing, returns RspRData=0 and RspErr=1.
- Store:
  - Read-modify-write of word addr[ADDR_WIDTH-1:2].
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces the half selected by addr[1] with wdata[15:0].
  - SW replaces the whole word.
  - The write commits exactly once, on the edge that enters RESP.
- Load:
  - Select the byte or half by addr[1:0].
  - B/H sign-extend; BU/HU zero-extend.
  - The result is registered into RspRData on the edge entering RESP.
- Memory contents are not reset; they are initialised from file only in simulation.

## Timing
- Reset values: ReqReady=1, RspValid=0, RspRData=0, RspErr=0, state IDLE, counter 0.
- Request accepted at edge N → RspValid=1 from edge N+LATENCY.
- Minimum request spacing is LATENCY+1 cycles.
- There is no combinational path from RspReady to ReqReady; ReqReady rises the cycle after the response handshake.
- A ReqValid seen while not in IDLE is ignored; the requester must hold the request until ReqReady.
- Backpressure: RspReady low holds RESP indefinitely, with no re-access and no second write.
- A store followed by a load to the same word returns the merged value (the write commits before the next accept).
- Reset asserted mid-WAIT: the pending store is discarded and memory is unchanged.
- Reset asserted in RESP: the response is dropped and ReqReady=1 immediately.
- All outputs are driven from registers or decoded state only.

## Structure
- Shared package mem_pkg holds:
  - the funct3 enum (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU);
  - the FSM state enum;
  - the width localparams.
- Sub-module mem_lane_align (combinational) takes the offset, type, stored word and wdata, and produces the merged store word, the extended load value and the misalign flag.
  - The core and the responder reuse it for byte-lane logic.
- The top level holds the FSM, counter, request latch and memory array.

## Test plan
- Reset, then SW 0xDEADBEEF to 0x100 and LW from 0x100 (LATENCY=2) → RspValid 2 cycles after each accept; RData=0xDEADBEEF, Err=0.
- SB 0x7F to 0x101 over 0xDEADBEEF, then LB/LBU from 0x103 → word 0xDEAD7FEF; LB=0xFFFFFFDE, LBU=0x000000DE.
- LH from 0x102 → 0xFFFFDEAD; LH from 0x101 → Err=1, RData=0, memory unchanged.
- SW to 0x20000 (≥2**17) → Err=1, no write; a subsequent LW 0x0 is unaffected.
- Hold RspReady=0 for 5 cycles during an SB → RspValid and RData stable, a single write, ReqReady=0 throughout.
- Assert RSTn=0 one cycle after accepting SW 0x11111111 to 0x100 → 0x100 retains its prior value; outputs return to reset values asynchronously.
